// File: rtl/buffers_pkg.sv
// -----------------------------------------------------------------------------
// buffers_pkg
//   Shared types for the serial buffer blocks.
//   piso_state_e : control state of the parallel-in/serial-out transmitter.
//       PISO_IDLE  - no word in flight; the block is ready for a new word
//       PISO_SHIFT - a word is being streamed out one bit per enabled cycle
// -----------------------------------------------------------------------------
package buffers_pkg;

    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_e;

endpackage : buffers_pkg

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out transmitter. A DataWidth-bit word is taken over a
//   valid/ready handshake and shifted out one bit per cycle with en_i=1,
//   together with first/last framing strobes. When the source keeps
//   data_valid_i high, consecutive words stream with no idle cycle between
//   them: the next word is loaded on the same edge that consumes the last
//   bit of the current word.
//
// Parameters
//   DataWidth   word width in bits (>= 2)
//   MsbFirst    1: bit DataWidth-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk_i         clock, all state changes on posedge
//   rst_i         synchronous active-high reset, highest priority
//   en_i          shift enable; current bit is consumed at a posedge with en_i=1
//   data_i        parallel word
//   data_valid_i  data_i is valid
//   data_ready_o  word can be accepted this cycle (combinational on en_i)
//   ser_o         current serial bit (0 when idle)
//   ser_valid_o   ser_o carries a bit of a word
//   ser_first_o   ser_o is the first bit of its word
//   ser_last_o    ser_o is the last bit of its word
//   busy_o        a word is in flight
// -----------------------------------------------------------------------------
module piso_serializer
    import buffers_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter bit MsbFirst  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic                 ser_o,
    output logic                 ser_valid_o,
    output logic                 ser_first_o,
    output logic                 ser_last_o,
    output logic                 busy_o
);

    // A one-bit word has no distinct first/last position and the counter
    // would collapse to zero width.
    generate
        if (DataWidth < 2) begin : g_width_check
            $error("piso_serializer: DataWidth must be >= 2");
        end
    endgenerate

    localparam int             CntW     = $clog2(DataWidth);
    localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);

    piso_state_e            state_reg;
    logic [DataWidth-1:0]   shreg_reg;
    logic [CntW-1:0]        cnt_reg;

    logic                   in_shift;
    logic                   cnt_last;
    logic                   accept;
    logic [DataWidth-1:0]   shreg_shifted;

    assign in_shift = (state_reg == PISO_SHIFT);
    assign cnt_last = (cnt_reg == LastCnt);

    // Ready either when idle, or on the cycle whose edge consumes the last
    // bit of the current word, so a waiting word slides in without a gap.
    assign data_ready_o = !in_shift || (en_i && cnt_last);
    assign accept       = data_valid_i && data_ready_o;

    // Move the next bit toward the output end, zero fill behind it.
    generate
        if (MsbFirst) begin : g_shift_msb
            assign shreg_shifted = {shreg_reg[DataWidth-2:0], 1'b0};
        end else begin : g_shift_lsb
            assign shreg_shifted = {1'b0, shreg_reg[DataWidth-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= PISO_IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (accept) begin
            // Covers both a load from idle and the zero-bubble reload on wrap.
            state_reg <= PISO_SHIFT;
            shreg_reg <= data_i;
            cnt_reg   <= '0;
        end else if (in_shift && en_i) begin
            if (cnt_last) begin
                state_reg <= PISO_IDLE;
                cnt_reg   <= '0;
            end else begin
                shreg_reg <= shreg_shifted;
                cnt_reg   <= cnt_reg + 1'b1;
            end
        end
    end

    // Outputs decode registered state only, so they hold steady while en_i
    // is low and never glitch with the enable.
    generate
        if (MsbFirst) begin : g_out_msb
            assign ser_o = in_shift && shreg_reg[DataWidth-1];
        end else begin : g_out_lsb
            assign ser_o = in_shift && shreg_reg[0];
        end
    endgenerate

    assign ser_valid_o = in_shift;
    assign ser_first_o = in_shift && (cnt_reg == '0);
    assign ser_last_o  = in_shift && cnt_last;
    assign busy_o      = in_shift;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Two instances share one stimulus: index 0 sends MSB first, index 1 sends
//   LSB first. Every accepted word pushes its expected bit stream into a
//   per-instance queue; a negedge monitor compares outputs against the head
//   of each queue and pops it on every consuming edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [7:0] data_i;
    logic       data_valid_i;

    logic [1:0] ready;
    logic [1:0] ser;
    logic [1:0] ser_valid;
    logic [1:0] ser_first;
    logic [1:0] ser_last;
    logic [1:0] busy;

    exp_t exp_q[2][$];

    int checks = 0;
    int errors = 0;

    int en_mode  = 2;   // 0: en_i=1, 1: pattern 1,0,0 repeating, 2: random
    int en_phase = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DataWidth(8), .MsbFirst(1'b1)) u_msb (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (ready[0]),
        .ser_o        (ser[0]),
        .ser_valid_o  (ser_valid[0]),
        .ser_first_o  (ser_first[0]),
        .ser_last_o   (ser_last[0]),
        .busy_o       (busy[0])
    );

    piso_serializer #(.DataWidth(8), .MsbFirst(1'b0)) u_lsb (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (ready[1]),
        .ser_o        (ser[1]),
        .ser_valid_o  (ser_valid[1]),
        .ser_first_o  (ser_first[1]),
        .ser_last_o   (ser_last[1]),
        .busy_o       (busy[1])
    );

    task automatic chk(input string nm, input int d, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, d, act, req, $time);
        end
    endtask

    // Enable driver, updated just after each posedge.
    always @(posedge clk) begin
        #1;
        if (en_mode == 0) begin
            en_i = 1'b1;
        end else if (en_mode == 1) begin
            en_i = (en_phase == 0);
            en_phase = (en_phase + 1) % 3;
        end else begin
            en_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard.
    bit   m_ne;
    bit   m_rdy;
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst_i) begin
            for (int d = 0; d < 2; d++) begin
                m_ne  = (exp_q[d].size() != 0);
                m_rdy = !m_ne || (en_i && exp_q[d][0].l);
                chk("ready", d, 8'(ready[d]), 8'(m_rdy));
                chk("valid", d, 8'(ser_valid[d]), 8'(m_ne));
                chk("busy",  d, 8'(busy[d]), 8'(m_ne));
                if (m_ne) begin
                    m_e = exp_q[d][0];
                    chk("ser",   d, 8'(ser[d]), 8'(m_e.b));
                    chk("first", d, 8'(ser_first[d]), 8'(m_e.f));
                    chk("last",  d, 8'(ser_last[d]), 8'(m_e.l));
                    if (en_i) void'(exp_q[d].pop_front());
                end else begin
                    chk("idle_ser",   d, 8'(ser[d]), 8'd0);
                    chk("idle_first", d, 8'(ser_first[d]), 8'd0);
                    chk("idle_last",  d, 8'(ser_last[d]), 8'd0);
                end
            end
        end
    end

    task automatic push_word(input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.f = (i == 0);
            e.l = (i == 7);
            e.b = w[7-i];
            exp_q[0].push_back(e);
            e.b = w[i];
            exp_q[1].push_back(e);
        end
        $display("word %02h accepted t=%0t", w, $time);
    endtask

    // Offer a word and hold it until accepted; returns 1 ns after the accept edge
    // with data_valid_i still high.
    task automatic send(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        data_i = w;
        data_valid_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout word=%02h actual=not_ready required=ready", w);
        end else begin
            @(posedge clk);
            push_word(w);
            #1;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && busy == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_ser"},   d, 8'(ser[d]), 8'd0);
            chk({tag, "_valid"}, d, 8'(ser_valid[d]), 8'd0);
            chk({tag, "_first"}, d, 8'(ser_first[d]), 8'd0);
            chk({tag, "_last"},  d, 8'(ser_last[d]), 8'd0);
            chk({tag, "_busy"},  d, 8'(busy[d]), 8'd0);
            chk({tag, "_ready"}, d, 8'(ready[d]), 8'd1);
        end
        $display("reset check %s t=%0t", tag, $time);
    endtask

    initial begin
        rst_i = 1'b1;
        en_i = 1'b0;
        data_i = 8'h00;
        data_valid_i = 1'b0;

        // 1. reset held two cycles with random inputs
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            data_i = 8'($urandom);
            data_valid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_reset("reset");
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        data_valid_i = 1'b0;
        en_mode = 0;
        exp_q[0].delete();
        exp_q[1].delete();
        @(posedge clk);
        #1;

        // 2. single word, continuous enable
        send(8'hA5);
        data_valid_i = 1'b0;
        drain();

        // 3. two words back to back, no bubble
        send(8'h01);
        send(8'h80);
        data_valid_i = 1'b0;
        drain();

        // 4. enable pattern 1,0,0 repeating
        en_phase = 0;
        en_mode = 1;
        @(posedge clk);
        #1;
        send(8'h3C);
        data_valid_i = 1'b0;
        drain();
        en_mode = 0;
        @(posedge clk);
        #1;

        // 5. offer while busy at cnt=3, accepted only on the wrap cycle
        send(8'h5A);
        data_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(8'hFF);
        data_valid_i = 1'b0;
        drain();

        // 6. reset in the middle of a word
        send(8'hC3);
        data_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        @(negedge clk);
        check_reset("midreset");
        @(posedge clk);
        #1;
        send(8'h0F);
        data_valid_i = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_piso_serializer
